// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    OVER       = 2'd2
  } state_t;

  localparam int SCORE_W_DEFAULT = 4;

  localparam int               STEP_W   = 3;
  localparam logic [STEP_W-1:0] STEP_MAX = 3'd7;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Serve speed: speed_sel 0..3 maps to 1..4 pixels per frame.
  function automatic logic [STEP_W-1:0] base_step(input logic [1:0] sel);
    return {1'b0, sel} + 3'd1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Ball event / ball control link between the game datapath (master) and the match controller (slave).
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic              frame_tick;
  logic              left_miss;
  logic              right_miss;
  logic              paddle_hit;
  logic              ball_run;
  logic              ball_center;
  logic              serve_dir;
  logic [STEP_W-1:0] ball_step;

  modport master (
    output frame_tick, left_miss, right_miss, paddle_hit,
    input  ball_run, ball_center, serve_dir, ball_step
  );

  modport slave (
    input  frame_tick, left_miss, right_miss, paddle_hit,
    output ball_run, ball_center, serve_dir, ball_step
  );

endinterface

// File: rtl/pong_edge_det.sv
// Registered rising-edge detector; history resets high so a level held through reset never fires.
module pong_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, scoring, winner and ball speed.
// Optional `PONG_RALLY_SPEEDUP_EN: ball_step rises every RALLY_HITS paddle hits within a rally.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = SCORE_W_DEFAULT
`ifdef PONG_RALLY_SPEEDUP_EN
  , parameter int RALLY_HITS = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pong_match_ctrl_if.slave   ball,
  input  logic               score_reset,
  input  logic [1:0]         speed_sel,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  localparam int                 CNT_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state, state_d;
  logic [CNT_W-1:0]   frame_cnt, cnt_d;
  logic               center_q, center_d;
  logic               dir_q, dir_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic               winner_q, winner_d;
  logic               reset_rise;

`ifdef PONG_RALLY_SPEEDUP_EN
  localparam int               HIT_W    = (RALLY_HITS > 1) ? $clog2(RALLY_HITS) : 1;
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(RALLY_HITS - 1);
  logic [HIT_W-1:0] hit_cnt, hit_d;
`endif

  pong_edge_det u_score_reset_edge (
    .clk   (clk),
    .rst   (rst),
    .level (score_reset),
    .rise  (reset_rise)
  );

  // Scores stay below WIN_SCORE while incrementable, so these never wrap.
  assign score_l_inc = score_l_q + 1'b1;
  assign score_r_inc = score_r_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SERVE_WAIT;
      frame_cnt <= '0;
      center_q  <= 1'b0;
      dir_q     <= DIR_RIGHT;
      step_q    <= 3'd1;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 1'b0;
`ifdef PONG_RALLY_SPEEDUP_EN
      hit_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      frame_cnt <= cnt_d;
      center_q  <= center_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
`ifdef PONG_RALLY_SPEEDUP_EN
      hit_cnt   <= hit_d;
`endif
    end
  end

  // NOTE: every value written here is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = frame_cnt;
    center_d  = 1'b0;
    dir_d     = dir_q;
    step_d    = step_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
`ifdef PONG_RALLY_SPEEDUP_EN
    hit_d     = hit_cnt;
`endif

    // A score_reset press overrides everything, including a same-cycle miss.
    if (reset_rise) begin
      state_d   = SERVE_WAIT;
      cnt_d     = '0;
      center_d  = 1'b1;
      dir_d     = DIR_RIGHT;
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = 1'b0;
    end else begin
      case (state)
        SERVE_WAIT: begin
          if (ball.frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
              state_d = PLAY;
              cnt_d   = '0;
              step_d  = base_step(speed_sel);
`ifdef PONG_RALLY_SPEEDUP_EN
              hit_d   = '0;
`endif
            end else begin
              cnt_d = frame_cnt + 1'b1;
            end
          end
        end

        PLAY: begin
          if (ball.left_miss || ball.right_miss) begin
            state_d  = SERVE_WAIT;
            cnt_d    = '0;
            center_d = 1'b1;
            // A double miss is a dead ball: recentre without scoring.
            if (ball.left_miss && !ball.right_miss) begin
              score_r_d = score_r_inc;
              dir_d     = DIR_LEFT;
              if (score_r_inc == WIN) begin
                state_d  = OVER;
                winner_d = 1'b1;
              end
            end else if (ball.right_miss && !ball.left_miss) begin
              score_l_d = score_l_inc;
              dir_d     = DIR_RIGHT;
              if (score_l_inc == WIN) begin
                state_d  = OVER;
                winner_d = 1'b0;
              end
            end
          end
`ifdef PONG_RALLY_SPEEDUP_EN
          else if (ball.paddle_hit) begin
            if (hit_cnt == HIT_LAST) begin
              hit_d = '0;
              if (step_q != STEP_MAX) step_d = step_q + 1'b1;
            end else begin
              hit_d = hit_cnt + 1'b1;
            end
          end
`endif
        end

        OVER: ;

        default: state_d = SERVE_WAIT;
      endcase
    end
  end

  always_comb begin
    ball.ball_run    = (state == PLAY);
    ball.ball_center = center_q;
    ball.serve_dir   = dir_q;
    ball.ball_step   = step_q;
    score_l          = score_l_q;
    score_r          = score_r_q;
    game_over        = (state == OVER);
    winner           = winner_q;
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=3, SERVE_FRAMES=2; covers both PONG_RALLY_SPEEDUP_EN builds.
module tb_pong_match_ctrl;

  typedef struct packed {
    logic       run;
    logic       center;
    logic       dir;
    logic [2:0] step;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
    logic       win;
  } st_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       score_reset;
  logic [1:0] speed_sel;
  logic [3:0] score_l, score_r;
  logic       game_over, winner;

  int  tests_run    = 0;
  int  tests_failed = 0;
  st_t got, exp;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .SCORE_W      (4)
`ifdef PONG_RALLY_SPEEDUP_EN
    , .RALLY_HITS (4)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ball        (bus),
    .score_reset (score_reset),
    .speed_sel   (speed_sel),
    .score_l     (score_l),
    .score_r     (score_r),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  function automatic st_t snap();
    return '{bus.ball_run, bus.ball_center, bus.serve_dir, bus.ball_step,
             score_l, score_r, game_over, winner};
  endfunction

  function automatic st_t mk(input logic r, c, d, input int st, sl, sr, input logic go, w);
    return '{r, c, d, 3'(st), 4'(sl), 4'(sr), go, w};
  endfunction

  // Inputs change at negedge; one posedge later the outputs are sampled at the next negedge.
  task automatic step(input logic ft, lm, rm, ph);
    bus.frame_tick = ft;
    bus.left_miss  = lm;
    bus.right_miss = rm;
    bus.paddle_hit = ph;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.left_miss  = 1'b0;
    bus.right_miss = 1'b0;
    bus.paddle_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    score_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp = mk(0,0,1,1,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL reset_values: got %p expected %p", got, exp); end
    rst = 1'b0;
    step(0,0,0,0);
    exp = mk(0,0,1,1,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL reset_held_button: got %p expected %p", got, exp); end
    score_reset = 1'b0;
    step(0,0,0,0);
  endtask

  task automatic test_serve();
    speed_sel = 2'd2;
    step(1,0,0,0);
    exp = mk(0,0,1,1,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL serve_tick1: got %p expected %p", got, exp); end
    step(0,0,0,0);
    got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL serve_idle: got %p expected %p", got, exp); end
    step(1,0,0,0);
    exp = mk(1,0,1,3,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL serve_tick2: got %p expected %p", got, exp); end
  endtask

  task automatic test_point();
    step(0,0,1,0);
    exp = mk(0,1,1,3,1,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL point_score: got %p expected %p", got, exp); end
    step(0,0,0,0);
    exp = mk(0,0,1,3,1,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL point_center_once: got %p expected %p", got, exp); end
    step(0,0,1,0);
    got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL point_miss_in_wait: got %p expected %p", got, exp); end
  endtask

  task automatic test_miss_vs_tick();
    step(1,0,0,0);
    step(1,0,0,0);
    exp = mk(1,0,1,3,1,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL mvt_serve: got %p expected %p", got, exp); end
    step(1,1,0,0);
    exp = mk(0,1,0,3,1,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL mvt_miss_wins: got %p expected %p", got, exp); end
    step(1,0,0,0);
    exp = mk(0,0,0,3,1,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL mvt_count_cleared: got %p expected %p", got, exp); end
    step(1,0,0,0);
    exp = mk(1,0,0,3,1,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL mvt_reserve: got %p expected %p", got, exp); end
  endtask

  task automatic test_win();
    step(0,1,0,0);
    exp = mk(0,1,0,3,1,2,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL win_point2: got %p expected %p", got, exp); end
    step(1,0,0,0);
    step(1,0,0,0);
    step(0,1,0,0);
    exp = mk(0,1,0,3,1,3,1,1); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL win_over: got %p expected %p", got, exp); end
    step(0,1,0,0);
    step(0,0,1,0);
    for (int i = 0; i < 3; i++) step(1,0,0,0);
    exp = mk(0,0,0,3,1,3,1,1); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL win_frozen: got %p expected %p", got, exp); end
    score_reset = 1'b1;
    step(0,0,0,0);
    exp = mk(0,1,1,3,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL win_score_reset: got %p expected %p", got, exp); end
    step(0,0,0,0);
    exp = mk(0,0,1,3,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL win_reset_level_held: got %p expected %p", got, exp); end
    score_reset = 1'b0;
    step(0,0,0,0);
  endtask

  task automatic test_simultaneous();
    step(1,0,0,0);
    step(1,0,0,0);
    step(0,1,0,0);
    exp = mk(0,1,0,3,0,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL sim_setup_point: got %p expected %p", got, exp); end
    step(1,0,0,0);
    step(1,0,0,0);
    step(0,1,1,0);
    exp = mk(0,1,0,3,0,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL sim_double_miss: got %p expected %p", got, exp); end
    step(1,0,0,0);
    step(1,0,0,0);
    exp = mk(1,0,0,3,0,1,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL sim_reserve: got %p expected %p", got, exp); end
    score_reset = 1'b1;
    step(0,0,1,0);
    exp = mk(0,1,1,3,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL sim_reset_beats_miss: got %p expected %p", got, exp); end
    score_reset = 1'b0;
    step(0,0,0,0);
  endtask

  task automatic test_speed_latch();
    speed_sel = 2'd1;
    step(1,0,0,0);
    step(1,0,0,0);
    exp = mk(1,0,1,2,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL latch_serve: got %p expected %p", got, exp); end
    speed_sel = 2'd3;
    step(1,0,0,0);
    step(1,0,0,0);
    got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL latch_mid_rally: got %p expected %p", got, exp); end
    step(0,0,1,0);
    exp = mk(0,1,1,2,1,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL latch_point: got %p expected %p", got, exp); end
    step(1,0,0,0);
    step(1,0,0,0);
    exp = mk(1,0,1,4,1,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL latch_next_serve: got %p expected %p", got, exp); end
  endtask

  task automatic test_rally();
    int steps_en [5] = '{4, 5, 6, 7, 7};
    int s;
    for (int k = 1; k <= 16; k++) begin
      step(0,0,0,1);
`ifdef PONG_RALLY_SPEEDUP_EN
      s = steps_en[k / 4];
`else
      s = 4;
`endif
      exp = mk(1,0,1,s,1,0,0,0); got = snap(); tests_run++;
      if (got !== exp) begin tests_failed++; $display("FAIL rally_hit%0d: got %p expected %p", k, got, exp); end
    end
    step(0,0,1,0);
    step(1,0,0,0);
    step(1,0,0,0);
    exp = mk(1,0,1,4,2,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rally_reload: got %p expected %p", got, exp); end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    @(negedge clk);
    exp = mk(0,0,1,1,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rst_mid_rally: got %p expected %p", got, exp); end
    rst = 1'b0;
    step(1,0,0,0);
    got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rst_count_cleared: got %p expected %p", got, exp); end
    step(1,0,0,0);
    exp = mk(1,0,1,4,0,0,0,0); got = snap(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rst_reserve: got %p expected %p", got, exp); end
  endtask

  initial begin
    rst            = 1'b1;
    score_reset    = 1'b0;
    speed_sel      = 2'd0;
    bus.frame_tick = 1'b0;
    bus.left_miss  = 1'b0;
    bus.right_miss = 1'b0;
    bus.paddle_hit = 1'b0;
    test_reset();
    test_serve();
    test_point();
    test_miss_vs_tick();
    test_win();
    test_simultaneous();
    test_speed_latch();
    test_rally();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
